// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: access sizes,
// IO address decode, controller states and requester identities.
package mem_ctrl_pkg;

  localparam logic [1:0]  SZ_B = 2'd0;
  localparam logic [1:0]  SZ_H = 2'd1;
  localparam logic [1:0]  SZ_W = 2'd2;

  // Default IO window: any address with bits [17:16] both set.
  localparam logic [31:0] IO_BASE_ADDR = 32'h0003_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE} state_e;
  typedef enum logic       {OWN_IF, OWN_LS}              owner_e;

  // An address is IO when every bit set in the base is also set in it.
  function automatic logic is_io(input logic [31:0] a, input logic [31:0] base);
    return (a & base) == base;
  endfunction

  // Number of byte cycles for an access; the unused size code is a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Bytes are shifted in from the top, so a short read ends up in the high
  // lanes; move it down and zero the rest.
  function automatic logic [31:0] rd_align(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd1:    return {24'b0, w[31:24]};
      3'd2:    return {16'b0, w[31:16]};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Combinational grant between instruction fetch and the load/store buffer.
// Build option MEM_CTRL_RR_EN: round-robin on contention instead of LS-first.
module mem_arbiter
  import mem_ctrl_pkg::*;
(
`ifdef MEM_CTRL_RR_EN
  input  owner_e last_owner,
`endif
  input  logic   if_req,
  input  logic   ls_req,
  input  logic   ls_we,
  input  logic   flush,
  input  logic   busy,
  output logic   gnt,
  output owner_e gnt_own,
  output logic   gnt_we
);

  // Pick a winner; nothing is granted while busy or while a flush is live.
  always_comb begin
    gnt     = !busy && !flush && (if_req || ls_req);
    gnt_own = OWN_LS;
    if (if_req && ls_req) begin
`ifdef MEM_CTRL_RR_EN
      gnt_own = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
`else
      gnt_own = OWN_LS;
`endif
    end else if (if_req) begin
      gnt_own = OWN_IF;
    end
    gnt_we = (gnt_own == OWN_LS) && ls_we;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Single-port memory controller: serialises IF and LS accesses onto the
// byte-wide RAM/IO bus, with IO write backpressure and flush cancellation.
// Build option MEM_CTRL_RR_EN: round-robin arbitration between requesters.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W  = 32,
  parameter logic [31:0] IO_BASE = IO_BASE_ADDR
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [1:0]        ls_size,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata
);

  state_e      state, state_nxt;
  owner_e      owner_q;
  logic [2:0]  cnt;       // READ: bus cycles elapsed; WRITE: bytes driven
  logic [2:0]  nbytes;
  logic        io_q;
  logic        mem_wr_q;
  logic [31:0] wbuf;      // remaining store bytes, next one in [7:0]
  logic [31:0] rbuf;      // read bytes shifted in from the top
  logic [31:0] rd_shift;
  logic        busy;
  logic        gnt, gnt_we;
  owner_e      gnt_own;

`ifdef MEM_CTRL_RR_EN
  owner_e      last_owner;
`endif

  // The done pulse counts as busy, which gives the one-cycle bubble that
  // keeps a requester from being granted twice before it drops req.
  assign busy     = (state != ST_IDLE) || if_done || ls_done;
  assign rd_shift = {mem_din, rbuf[31:8]};
  assign mem_wr   = mem_wr_q && rdy_in;

  mem_arbiter u_arb (
`ifdef MEM_CTRL_RR_EN
    .last_owner (last_owner),
`endif
    .if_req     (if_req),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .flush      (flush),
    .busy       (busy),
    .gnt        (gnt),
    .gnt_own    (gnt_own),
    .gnt_we     (gnt_we)
  );

  // Next-state: reads end on flush or after the last byte lands, writes
  // end after the last byte has been driven (flush never cancels them).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (gnt) state_nxt = gnt_we ? ST_WRITE : ST_READ;
      ST_READ:  if (flush || cnt == nbytes) state_nxt = ST_IDLE;
      ST_WRITE: if (cnt == nbytes) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register; rdy_in low freezes it.
  always_ff @(posedge clk_in) begin
    if (rst_in)      state <= ST_IDLE;
    else if (rdy_in) state <= state_nxt;
  end

`ifdef MEM_CTRL_RR_EN
  // Remember who was served last; starts at LS so IF wins first contention.
  always_ff @(posedge clk_in) begin
    if (rst_in)                                  last_owner <= OWN_LS;
    else if (rdy_in && state == ST_IDLE && gnt)  last_owner <= gnt_own;
  end
`endif

  // Bus and datapath registers: latch the access at grant, then step one
  // byte per cycle. Result registers only change when a done is issued.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_a    <= '0;
      mem_dout <= '0;
      mem_wr_q <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
      cnt      <= '0;
      nbytes   <= '0;
      io_q     <= 1'b0;
      owner_q  <= OWN_IF;
      wbuf     <= '0;
      rbuf     <= '0;
    end else if (rdy_in) begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt) begin
            owner_q <= gnt_own;
            cnt     <= '0;
            nbytes  <= (gnt_own == OWN_IF) ? 3'd4 : size_bytes(ls_size);
            mem_a   <= (gnt_own == OWN_IF) ? if_addr : ls_addr;
            io_q    <= is_io(32'(ls_addr), IO_BASE);
            if (gnt_we) begin
              if (is_io(32'(ls_addr), IO_BASE) && io_buffer_full) begin
                // UART full: hold the first byte back.
                mem_wr_q <= 1'b0;
                wbuf     <= ls_wdata;
              end else begin
                mem_wr_q <= 1'b1;
                mem_dout <= ls_wdata[7:0];
                wbuf     <= ls_wdata >> 8;
                cnt      <= 3'd1;
              end
            end
          end
        end
        ST_READ: begin
          if (!flush) begin
            if (cnt != 3'd0)            rbuf  <= rd_shift;
            if (cnt + 3'd1 < nbytes)    mem_a <= mem_a + ADDR_W'(1);
            cnt <= cnt + 3'd1;
            if (cnt == nbytes) begin
              if (owner_q == OWN_IF) begin
                if_data <= rd_align(rd_shift, nbytes);
                if_done <= 1'b1;
              end else begin
                ls_rdata <= rd_align(rd_shift, nbytes);
                ls_done  <= 1'b1;
              end
            end
          end
        end
        ST_WRITE: begin
          if (cnt == nbytes) begin
            mem_wr_q <= 1'b0;
            ls_done  <= 1'b1;
          end else if (io_q && io_buffer_full) begin
            mem_wr_q <= 1'b0;
          end else begin
            // mem_a already points at byte 0 if nothing has been written yet.
            if (cnt != 3'd0) mem_a <= mem_a + ADDR_W'(1);
            mem_dout <= wbuf[7:0];
            wbuf     <= wbuf >> 8;
            mem_wr_q <= 1'b1;
            cnt      <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller between the CPU core and the byte-wide RAM/IO bus inside riscv_top.
- Arbitrates between instruction fetch (IF, 4-byte reads) and the load/store buffer (LS, 1/2/4-byte reads or writes).
- Serialises each access into byte cycles, handles IO-write backpressure, and supports flush cancellation.

Parameters:
- ADDR_W, 32, address width
- IO_BASE, 32'h30000, addresses with addr[17:16]==2'b11 are IO space

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous reset, active-high
- rdy_in  input  1  global ready; low freezes the block
- mem_din  input  8  RAM/IO read byte, valid one cycle after its address was driven
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1 = write, 0 = read
- io_buffer_full  input  1  UART tx buffer full
- flush  input  1  branch mispredict; cancels fetch and loads
- if_req  input  1  fetch request, held until if_done
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word, little-endian
- ls_req  input  1  load/store request, held until ls_done
- ls_we  input  1  1 = store
- ls_size  input  2  0 = byte, 1 = half, 2 = word
- ls_addr  input  32  access address
- ls_wdata  input  32  store data, low bytes used
- ls_done  output  1  one-cycle pulse
- ls_rdata  output  32  load data, zero-extended; LSB sign-extends

Behaviour:
- Clocking and reset:
  - Everything is synchronous to clk_in.
  - rst_in (sync, high) forces state IDLE; mem_a=0, mem_dout=0, mem_wr=0, if_done=0, ls_done=0, if_data=0, ls_rdata=0, counters=0.
- rdy_in=0: all registers hold; mem_wr is forced 0 combinationally.
- States: IDLE, READ, WRITE.
- IDLE:
  - Grant is evaluated only when the done pulse from the previous access is low, which inserts a one-cycle bubble.
  - Priority: LS over IF.
  - ls_req & ls_we goes to WRITE; ls_req & !ls_we goes to READ; else if_req goes to READ with size=word.
  - Latch address, size, data and owner.
  - Requests are ignored in any cycle where flush=1.
- READ:
  - Drive mem_a = base + k for k = 0..N-1, one byte per cycle, with mem_wr=0.
  - Capture mem_din into byte k-1 on each following cycle.
  - Request seen in cycle 0: addresses driven in cycles 1..N, bytes arrive in cycles 2..N+1, done plus data visible in cycle N+2. A word read completes in 6 cycles.
- WRITE:
  - Drive mem_a = base + k, mem_dout = wdata byte k, mem_wr=1 in cycles 1..N.
  - ls_done is high in cycle N+1.
  - IO address: before driving each byte, if io_buffer_full=1, hold that byte with mem_wr=0 until the flag clears.
- Address arithmetic is 32-bit wrapping; the controller does not check alignment.
- flush:
  - During a READ owned by IF or by a load, the controller returns to IDLE next cycle, emits no done, and leaves data registers unchanged.
  - A WRITE is never cancelled and completes normally.
  - flush in the same cycle as a done pulse does not retract the pulse.
- Requesters drop req on the cycle after done; the bubble guarantees no double grant.
- An IO read (byte only) proceeds as an ordinary 1-byte READ.

Optional Feature:
- Macro: MEM_CTRL_RR_EN.
- Defined: round-robin grant. When both requesters are pending, the one not served last wins. Last-owner register resets to LS, so IF wins the first contention.
- Undefined: fixed LS-over-IF priority as above.

Decomposition:
- Shared cpu_defs package/header:
  - size encodings (SZ_B/SZ_H/SZ_W)
  - IO_BASE and the is_io() predicate
  - state encodings
  - owner encodings (OWN_IF/OWN_LS)
- Sub-module mem_arbiter: combinational grant from if_req, ls_req, ls_we, flush, busy and last_owner. Its round-robin logic is guarded by MEM_CTRL_RR_EN.

Test Plan:
- Fetch: RAM[0x100..0x103] = 13,05,10,00; if_req at 0x100 in cycle 0 -> mem_a 0x100..0x103 in cycles 1-4, if_done in cycle 6 with if_data=0x00100513.
- Store: ls_req, ls_we=1, size=half, addr 0x204, wdata 0xABCD -> mem_wr=1 at 0x204 (0xCD) then 0x205 (0xAB); ls_done in cycle 3; RAM readback matches.
- Contention: if_req and ls_req (load byte, RAM[0x8]=0xFF) raised together -> without the macro LS is served first (ls_rdata=0x000000FF), then IF after the bubble; with MEM_CTRL_RR_EN, IF is served first.
- IO backpressure: store byte 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles -> mem_wr stays 0 throughout, then one write, ls_done one cycle later.
- Flush: flush in cycle 3 of a word fetch -> no if_done; IDLE next cycle. flush during a word store -> all 4 bytes written, ls_done asserted.
- Reset/freeze: rst_in mid-READ -> all outputs 0 next cycle. rdy_in=0 for 3 cycles mid-WRITE -> mem_wr=0 and byte index holds; the access resumes and completes correctly.
